kbd_matrix_scan: RTL and testbench
==================================

# kbd_matrix_scan

Parametrised keyboard-matrix scanner for the front-panel keypad: walks ROWS active-low row strobes, samples COLS active-low column returns, debounces every key independently, and publishes both a level vector of debounced key state and a FIFO-buffered stream of press/release events with a valid/ready handshake. It generalises the fixed 5×6 front-panel scanner to arbitrary matrix size, adds event queuing for the CPU-side monitor logic, and optionally adds typematic repeat.

## Interface
- ROWS, 5, number of row strobes (≥1)
- COLS, 6, number of column inputs (≥1)
- SETTLE, 8, cycles a row is driven before sampling (≥3)
- DEBOUNCE, 4, consecutive differing scans required to change a key (≥1)
- FIFO_DEPTH, 8, event queue entries (power of two, ≥2)
- REPEAT_DELAY, 40, full scans held before first repeat
- REPEAT_RATE, 8, full scans between repeats (1 ≤ REPEAT_RATE ≤ REPEAT_DELAY)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- kbd_row  out  ROWS  row strobes, one bit low at a time
- kbd_col  in  COLS  column returns, low = key closed; asynchronous
- key_state  out  ROWS*COLS  debounced state, bit row*COLS+col, 1 = pressed
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_code  out  clog2(ROWS*COLS)  key index row*COLS+col
- ev_press  out  1  1 = press, 0 = release
- ev_repeat  out  1  1 = typematic repeat event
- ev_overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ev_overflow

## Operation
- kbd_col passes through a 2-flop synchroniser before use.
- FSM: SETTLE → SAMPLE → EMIT → SETTLE (next row, wraps ROWS-1 → 0).
  - SETTLE: kbd_row = ~(1<<r); counts SETTLE cycles.
  - SAMPLE: one cycle, latches ~synchronised columns as raw[COLS-1:0].
  - EMIT: COLS cycles; cycle j processes key (r, j).
- Per-key debounce counter: if raw == key_state bit, counter ← 0; else counter+1; when it reaches DEBOUNCE, key_state bit ← raw, counter ← 0, push event {code, press=raw, repeat=0}.
- At most one push per cycle by construction.
- FIFO: pop on ev_valid & ev_ready. Push when full and no pop → event dropped, ev_overflow ← 1; key_state still updates. Push and pop same cycle when full → both succeed. Pop when empty → ignored.
- ev_overflow: set has priority over ovf_clr in the same cycle.
- Ghost keys (three-corner closures) are not suppressed.

## Timing
- Reset values: kbd_row all ones, key_state 0, all counters 0, FIFO empty, ev_valid 0, ev_code 0, ev_press 0, ev_repeat 0, ev_overflow 0, FSM in SETTLE row 0. First edge after rst deasserts drives kbd_row = ~1.
- Row period = SETTLE+1+COLS cycles; scan period = ROWS × that (75 cycles at defaults).
- Push in EMIT cycle t → ev_valid high at t+1 if FIFO was empty; head outputs registered, stable while ev_valid & !ev_ready.
- A stable change appears in key_state and the FIFO DEBOUNCE scans after it is first sampled; bounces shorter than DEBOUNCE scans produce nothing.
- rst asserted mid-scan: everything returns to reset values immediately; queued events discarded.

## Configuration
- KBD_SCAN_REPEAT_EN defined: a repeat tracker holds the most recently pressed key. When EMIT visits that key, it is still pressed, and no debounce event occurs, the scan count increments; at REPEAT_DELAY it pushes {code, press=1, repeat=1} and reloads to REPEAT_DELAY−REPEAT_RATE. Release of that key or any new press resets the tracker (new press becomes tracked key). Dropped repeats set ev_overflow.
- Not defined: no tracker logic; ev_repeat tied 0; REPEAT_* ignored.

## Test plan
- Reset, columns all 1 for 10 scans → kbd_row cycles ~1,~2,…,~16 every 15 cycles; ev_valid stays 0; key_state 0.
- Hold key (2,3) low from cycle 200 → after 4 scans key_state[15]=1 and one event code 15, press 1; release → one event code 15, press 0.
- Key (0,0) bounces 3 scans closed/1 open repeatedly → no events, key_state[0] stays 0.
- ev_ready held 0, toggle 10 distinct keys → exactly 8 events queued in order, ev_overflow=1; drain → 8 correct events; ovf_clr clears flag.
- With KBD_SCAN_REPEAT_EN, hold key 7 for 70 scans → press, then repeat events at scans 40, 48, 56, 64 after press (ev_repeat=1); release → release event, no further repeats.
- Assert rst mid-EMIT with 3 queued events → ev_valid 0, key_state 0 same cycle; scan restarts at row 0.

Source files
------------

// File: rtl/kbd_matrix_scan.sv
// kbd_matrix_scan: row-strobed keypad scanner with per-key debounce and a press/release event FIFO.
// Typematic repeat is compiled in when KBD_SCAN_REPEAT_EN is defined.
module kbd_matrix_scan #(
    parameter int unsigned ROWS         = 5,
    parameter int unsigned COLS         = 6,
    parameter int unsigned SETTLE       = 8,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned REPEAT_DELAY = 40,
    parameter int unsigned REPEAT_RATE  = 8,
    localparam int unsigned NKEYS       = ROWS * COLS,
    localparam int unsigned CW          = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  kbd_row,
    input  logic [COLS-1:0]  kbd_col,
    output logic [NKEYS-1:0] key_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CW-1:0]    ev_code,
    output logic             ev_press,
    output logic             ev_repeat,
    output logic             ev_overflow,
    input  logic             ovf_clr
);

    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SW  = $clog2(SETTLE);
    localparam int unsigned DW  = $clog2(DEBOUNCE + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
`ifdef KBD_SCAN_REPEAT_EN
    localparam int unsigned EW  = CW + 2;
    localparam int unsigned RPW = $clog2(REPEAT_DELAY + 1);
`else
    localparam int unsigned EW  = CW + 1;
`endif

    if (ROWS < 1 || COLS < 1 || SETTLE < 3 || DEBOUNCE < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
        $error("kbd_matrix_scan: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [SW-1:0]               set_cnt_q, set_cnt_d;
    logic [CLW-1:0]              col_q, col_d;
    logic [COLS-1:0]             raw_q, raw_d;
    logic [ROWS-1:0]             kbd_row_q, kbd_row_d;
    logic [COLS-1:0]             col_meta_q, col_sync_q;
    logic [NKEYS-1:0]            key_state_q, key_state_d;
    logic [NKEYS-1:0][DW-1:0]    db_cnt_q, db_cnt_d;
    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [AW:0]                 wr_q, wr_d, rd_q, rd_d;
    logic                        ovf_q, ovf_d;

    logic [CW-1:0] key_code;
    logic          raw_bit;
    logic          db_push, db_press;
    logic          push, pop, full, drop;
    logic [EW-1:0] entry, head;

    assign key_code = CW'(row_q * COLS + col_q);
    assign raw_bit  = raw_q[col_q];

    // Scan sequencer
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        set_cnt_d = set_cnt_q;
        col_d     = col_q;
        raw_d     = raw_q;
        case (state_q)
            ST_SETTLE: begin
                if (set_cnt_q == SW'(SETTLE - 1)) begin
                    set_cnt_d = '0;
                    state_d   = ST_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                raw_d   = ~col_sync_q;
                col_d   = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (col_q == CLW'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = ST_SETTLE;
                    row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
        kbd_row_d = ~(ROWS'(1) << row_d);
    end

    // Debounce of the key visited this EMIT cycle
    always_comb begin
        key_state_d = key_state_q;
        db_cnt_d    = db_cnt_q;
        db_push     = 1'b0;
        db_press    = 1'b0;
        if (state_q == ST_EMIT) begin
            if (raw_bit == key_state_q[key_code]) begin
                db_cnt_d[key_code] = '0;
            end else if (db_cnt_q[key_code] == DW'(DEBOUNCE - 1)) begin
                key_state_d[key_code] = raw_bit;
                db_cnt_d[key_code]    = '0;
                db_push               = 1'b1;
                db_press              = raw_bit;
            end else begin
                db_cnt_d[key_code] = db_cnt_q[key_code] + 1'b1;
            end
        end
    end

`ifdef KBD_SCAN_REPEAT_EN
    logic           rep_valid_q, rep_valid_d;
    logic [CW-1:0]  rep_code_q, rep_code_d;
    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
    logic           rep_push;

    // Tracker counts once per scan; the reload spaces later repeats REPEAT_RATE scans apart.
    always_comb begin
        rep_valid_d = rep_valid_q;
        rep_code_d  = rep_code_q;
        rep_cnt_d   = rep_cnt_q;
        rep_push    = 1'b0;
        if (state_q == ST_EMIT) begin
            if (db_push) begin
                if (db_press) begin
                    rep_valid_d = 1'b1;
                    rep_code_d  = key_code;
                    rep_cnt_d   = '0;
                end else if (rep_valid_q && rep_code_q == key_code) begin
                    rep_valid_d = 1'b0;
                    rep_cnt_d   = '0;
                end
            end else if (rep_valid_q && rep_code_q == key_code && key_state_q[key_code]) begin
                if (rep_cnt_q == RPW'(REPEAT_DELAY - 1)) begin
                    rep_push  = 1'b1;
                    rep_cnt_d = RPW'(REPEAT_DELAY - REPEAT_RATE);
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_valid_q <= 1'b0;
            rep_code_q  <= '0;
            rep_cnt_q   <= '0;
        end else begin
            rep_valid_q <= rep_valid_d;
            rep_code_q  <= rep_code_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign push  = db_push | rep_push;
    assign entry = db_push ? {key_code, db_press, 1'b0} : {key_code, 2'b11};
`else
    assign push  = db_push;
    assign entry = {key_code, db_press};
`endif

    // Event FIFO; a full queue still accepts a push when the head is popped in the same cycle
    assign ev_valid = (wr_q != rd_q);
    assign pop      = ev_valid & ev_ready;
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign drop     = push & full & ~pop;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        ovf_d = ovf_q;
        if (push && (!full || pop)) begin
            mem_d[wr_q[AW-1:0]] = entry;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SETTLE;
            row_q       <= '0;
            set_cnt_q   <= '0;
            col_q       <= '0;
            raw_q       <= '0;
            kbd_row_q   <= '1;
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            key_state_q <= '0;
            db_cnt_q    <= '0;
            mem_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            set_cnt_q   <= set_cnt_d;
            col_q       <= col_d;
            raw_q       <= raw_d;
            kbd_row_q   <= kbd_row_d;
            col_meta_q  <= kbd_col;
            col_sync_q  <= col_meta_q;
            key_state_q <= key_state_d;
            db_cnt_q    <= db_cnt_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
        end
    end

    assign head        = mem_q[rd_q[AW-1:0]];
    assign ev_code     = head[EW-1 -: CW];
    assign ev_press    = head[EW-1-CW];
`ifdef KBD_SCAN_REPEAT_EN
    assign ev_repeat   = head[0];
`else
    assign ev_repeat   = 1'b0;
`endif
    assign kbd_row     = kbd_row_q;
    assign key_state   = key_state_q;
    assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Directed bench for kbd_matrix_scan at default parameters (5x6 matrix, ideal-diode key model).
module tb_kbd_matrix_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  kbd_row;
    logic [5:0]  kbd_col;
    logic [29:0] key_state;
    logic        ev_valid, ev_ready, ev_press, ev_repeat, ev_overflow, ovf_clr;
    logic [4:0]  ev_code;

    logic [29:0] keys;
    int unsigned cyc = 0;
    int unsigned n_vec = 0, n_bad = 0;
    bit          seen_valid;

    kbd_matrix_scan dut (
        .clk(clk), .rst(rst), .kbd_row(kbd_row), .kbd_col(kbd_col),
        .key_state(key_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_press(ev_press), .ev_repeat(ev_repeat),
        .ev_overflow(ev_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        kbd_col = '1;
        for (int r = 0; r < 5; r++)
            if (!kbd_row[r])
                for (int c = 0; c < 6; c++)
                    if (keys[r*6+c]) kbd_col[c] = 1'b0;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_row(input logic [4:0] pat, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (kbd_row == pat) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            seen_valid |= ev_valid;
        end
    endtask

    task automatic wait_valid(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (ev_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic check_event(input string tag, input int unsigned code, input bit press);
        check_vec({tag, "_valid"}, ev_valid, 1);
        check_vec({tag, "_code"}, ev_code, code);
        check_vec({tag, "_press"}, ev_press, press);
        check_vec({tag, "_rep"}, ev_repeat, 0);
    endtask

    initial begin
        bit          ok;
        int unsigned t0, lat;
        logic [4:0]  exp_row, cur_row;
        logic [29:0] mask;
        int unsigned codes[10] = '{1, 4, 8, 11, 13, 17, 20, 22, 26, 29};

        rst = 1'b1; keys = '0; ev_ready = 1'b0; ovf_clr = 1'b0; seen_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("rst_row", kbd_row, 5'h1f);
        check_vec("rst_valid", ev_valid, 0);
        check_vec("rst_state", key_state, 0);
        check_vec("rst_ovf", ev_overflow, 0);
        check_vec("rst_code", ev_code, 0);
        check_vec("rst_press", ev_press, 0);
        check_vec("rst_rep", ev_repeat, 0);
        rst = 1'b0;
        @(negedge clk);
        check_vec("row_first", kbd_row, 5'b11110);

        // Row cadence over ten idle scans
        wait_row(5'b11101, 40, ok);
        check_vec("row1_reached", ok, 1);
        repeat (7) @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            exp_row = ~(5'b00001 << ((k + 1) % 5));
            check_vec("row_cadence", kbd_row, exp_row);
            repeat (15) begin
                @(negedge clk);
                seen_valid |= ev_valid;
            end
        end
        check_vec("idle_no_event", seen_valid, 0);
        check_vec("idle_state", key_state, 0);

        // Key (2,3) press and release
        keys[15] = 1'b1;
        t0 = cyc;
        wait_valid(1000, ok);
        check_vec("k15_press_seen", ok, 1);
        lat = cyc - t0;
        check_vec("k15_latency_window", (lat >= 220 && lat <= 320), 1);
        check_event("k15_press", 15, 1'b1);
        check_vec("k15_state_on", key_state, 30'h1 << 15);
        pop_one();
        check_vec("k15_popped", ev_valid, 0);
        keys[15] = 1'b0;
        wait_valid(1000, ok);
        check_vec("k15_rel_seen", ok, 1);
        check_event("k15_rel", 15, 1'b0);
        check_vec("k15_state_off", key_state, 0);
        pop_one();

        // Key (0,0) bounces: three scans closed, one open
        seen_valid = 1'b0;
        wait_row(5'b11110, 80, ok);
        wait_row(5'b11101, 20, ok);
        for (int s = 0; s < 16; s++) begin
            keys[0] = ((s % 4) != 3);
            wait_row(5'b11110, 80, ok);
            wait_row(5'b11101, 20, ok);
        end
        check_vec("bounce_align", ok, 1);
        keys[0] = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen_valid |= ev_valid;
        end
        check_vec("bounce_no_event", seen_valid, 0);
        check_vec("bounce_state", key_state, 0);

        // Ten presses into an eight-entry queue with the consumer stalled
        mask = '0;
        foreach (codes[i]) mask[codes[i]] = 1'b1;
        wait_row(5'b11101, 80, ok);
        wait_row(5'b11110, 80, ok);
        keys = mask;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ev_overflow) begin
                ok = 1'b1;
                break;
            end
        end
        check_vec("ovf_set", ok, 1);
        repeat (80) @(negedge clk);
        check_vec("ovf_state", key_state, mask);
        check_vec("ovf_head_held", ev_code, 1);
        for (int i = 0; i < 8; i++) begin
            check_event("drain", codes[i], 1'b1);
            pop_one();
        end
        check_vec("drain_empty", ev_valid, 0);
        check_vec("ovf_sticky", ev_overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_vec("ovf_cleared", ev_overflow, 0);

        // Reset in the middle of EMIT with events queued
        keys = '0;
        wait_valid(600, ok);
        check_vec("prerst_queue", ok, 1);
        cur_row = kbd_row;
        for (int i = 0; i < 20 && kbd_row == cur_row; i++) @(negedge clk);
        repeat (11) @(negedge clk);
        check_vec("prerst_valid", ev_valid, 1);
        rst = 1'b1;
        #1;
        check_vec("midrst_valid", ev_valid, 0);
        check_vec("midrst_state", key_state, 0);
        check_vec("midrst_row", kbd_row, 5'h1f);
        check_vec("midrst_ovf", ev_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_vec("restart_row0", kbd_row, 5'b11110);
        seen_valid = 1'b0;
        repeat (150) begin
            @(negedge clk);
            seen_valid |= ev_valid;
        end
        check_vec("restart_quiet", seen_valid, 0);

`ifdef KBD_SCAN_REPEAT_EN
        begin
            int unsigned ev_t[8];
            logic [4:0]  ev_c[8];
            bit          ev_p[8], ev_r[8];
            int unsigned nev = 0;
            ev_ready = 1'b1;
            keys[7] = 1'b1;
            for (int i = 0; i < 75 * 90; i++) begin
                @(negedge clk);
                if (ev_valid && nev < 8) begin
                    ev_t[nev] = cyc; ev_c[nev] = ev_code;
                    ev_p[nev] = ev_press; ev_r[nev] = ev_repeat;
                    nev++;
                end
                if (nev >= 1 && cyc == ev_t[0] + 66 * 75) keys[7] = 1'b0;
            end
            ev_ready = 1'b0;
            check_vec("rep_count", nev, 6);
            for (int k = 0; k < 6 && k < int'(nev); k++) begin
                check_vec("rep_code", ev_c[k], 7);
                check_vec("rep_press", ev_p[k], (k < 5));
                check_vec("rep_flag", ev_r[k], (k >= 1 && k <= 4));
                if (k >= 1 && k <= 4)
                    check_vec("rep_spacing", ev_t[k] - ev_t[0], (40 + 8 * (k - 1)) * 75);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
